rr_arb6_ctrl: RTL and testbench

//  Round-robin arbiter that shares one datapath resource among NREQ requesters.

---
 rtl/rr_arb6_ctrl.sv | 107 ++++++++++
 tb/tb_rr_arb6_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb6_ctrl.sv
// Round-robin arbiter with one-hot registered grant, rotating one-hot priority pointer
// and a hold timer that forcibly revokes grants held MAX_HOLD cycles.
module rr_arb6_ctrl #(
    parameter int NREQ     = 6,
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            CLRN,
    input  logic [NREQ-1:0] req,
    input  logic            rel,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic [NREQ-1:0] ptr,
    output logic            timeout,
    output logic            state_dbg
);

    // Handshake: req is a level held by each requester until it no longer needs the
    // resource; gnt answers one cycle after req is sampled and stays until rel,
    // the owner's req dropping, or the hold timer expiring.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [NREQ-1:0]  PTR_RST   = NREQ'(1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic [NREQ-1:0]   hi_req;
    logic [NREQ-1:0]   scan_src;
    logic [NREQ-1:0]   pick;
    logic              owner_req;
    logic              hold_exp;
    logic              do_exit;

    always_comb begin
        // Requests at or above the pointer win; otherwise wrap to the lowest request.
        hi_req    = req & ~(ptr_q - NREQ'(1));
        scan_src  = (|hi_req) ? hi_req : req;
        pick      = scan_src & (~scan_src + NREQ'(1));
        owner_req = |(req & gnt_q);
        hold_exp  = (hold_q == HOLD_LAST);
        do_exit   = rel || !owner_req || hold_exp;

        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = pick;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (do_exit) begin
                    gnt_d     = '0;
                    ptr_d     = {gnt_q[NREQ-2:0], gnt_q[NREQ-1]};
                    hold_d    = '0;
                    timeout_d = hold_exp && !rel && owner_req;
                    state_d   = IDLE;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge CLRN) begin
        if (!CLRN) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= PTR_RST;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = |gnt_q;
    assign ptr       = ptr_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_arb6_ctrl.sv
// Bench for rr_arb6_ctrl: directed scenarios then random traffic, all checked
// against an owner/pointer-index reference model.
module tb_rr_arb6_ctrl;

    localparam int NREQ     = 6;
    localparam int MAX_HOLD = 15;

    logic            clk;
    logic            CLRN;
    logic [NREQ-1:0] req;
    logic            rel;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [NREQ-1:0] ptr;
    logic            timeout;
    logic            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the resource, how long, and the priority index.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_len;
    bit m_to;

    logic [NREQ-1:0] exp_q[$];

    rr_arb6_ctrl #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .CLRN      (CLRN),
        .req       (req),
        .rel       (rel),
        .gnt       (gnt),
        .busy      (busy),
        .ptr       (ptr),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [NREQ-1:0] obs, input logic [NREQ-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot_of(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check_all();
        logic [NREQ-1:0] exp_gnt;
        exp_gnt = m_busy ? onehot_of(m_owner) : '0;
        check("gnt", gnt, exp_gnt);
        check("ptr", ptr, onehot_of(m_ptr));
        check("busy", NREQ'(busy), NREQ'(m_busy));
        check("timeout", NREQ'(timeout), NREQ'(m_to));
        check("state", NREQ'(state_dbg), NREQ'(m_busy));
        check("gnt_onehot0", NREQ'($onehot0(gnt)), NREQ'(1));
        check("ptr_onehot", NREQ'($onehot(ptr)), NREQ'(1));
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare mid-cycle.
    task automatic step();
        bit n_busy;
        int n_owner, n_ptr, n_len;
        bit n_to;
        n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_len = m_len; n_to = 1'b0;
        if (!m_busy) begin
            for (int i = 0; i < NREQ; i++) begin
                int idx;
                idx = (m_ptr + i) % NREQ;
                if (req[idx] && !n_busy) begin
                    n_busy = 1'b1; n_owner = idx; n_len = 1;
                end
            end
        end else if (rel || !req[m_owner] || m_len == MAX_HOLD) begin
            n_busy = 1'b0;
            n_ptr  = (m_owner + 1) % NREQ;
            n_to   = !rel && req[m_owner];
            n_len  = 0;
        end else begin
            n_len = m_len + 1;
        end
        @(posedge clk);
        m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_len = n_len; m_to = n_to;
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_len = 0; m_to = 1'b0;
    endtask

    // Assert reset away from any edge and confirm it acts without a clock.
    task automatic do_reset();
        #1;
        CLRN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        CLRN = 1'b1;
    endtask

    initial begin
        int k, hi;
        bit saw_to;
        CLRN = 1'b0;
        req  = '0;
        rel  = 1'b0;
        model_reset();

        // Reset with every requester active.
        req = 6'h3F;
        @(negedge clk);
        do_reset();
        req = '0;
        step();

        // Single requester, release, re-grant after one idle cycle.
        req = 6'h04;
        step();
        check("single_gnt", gnt, 6'h04);
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        check("single_rel_gnt", gnt, 6'h00);
        check("single_rel_ptr", ptr, 6'h08);
        step();
        check("single_regrant", gnt, 6'h04);
        req = '0;
        step();
        step();

        // Fairness: every requester gets a turn in order, wrapping back to 0.
        do_reset();
        exp_q = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        req = 6'h3F;
        while (exp_q.size() > 0) begin
            k = 0;
            while (gnt == '0 && k < 4) begin
                step();
                k++;
            end
            check("fair_order", gnt, exp_q.pop_front());
            step();
            step();
            rel = 1'b1;
            step();
            rel = 1'b0;
            check("fair_gap", gnt, 6'h00);
        end
        req = '0;
        step();

        // Hold timer revokes a grant kept too long.
        do_reset();
        req = 6'h01;
        hi = 0;
        saw_to = 1'b0;
        k = 0;
        while (!saw_to && k < 25) begin
            step();
            if (gnt != '0) hi++;
            saw_to = timeout;
            k++;
        end
        check("hold_len", NREQ'(hi), NREQ'(MAX_HOLD));
        check("hold_timeout", NREQ'(saw_to), NREQ'(1));
        check("hold_ptr", ptr, 6'h02);
        req = 6'h03;
        step();
        check("after_to_gnt", gnt, 6'h02);
        check("to_pulse_len", NREQ'(timeout), NREQ'(0));
        req = '0;
        step();
        step();

        // Release coinciding with hold expiry; owner dropping its request.
        do_reset();
        req = 6'h01;
        step();
        for (int i = 0; i < MAX_HOLD - 1; i++) step();
        check("tie_still_gnt", gnt, 6'h01);
        rel = 1'b1;
        step();
        rel = 1'b0;
        check("tie_gnt", gnt, 6'h00);
        check("tie_timeout", NREQ'(timeout), NREQ'(0));
        req = 6'h02;
        step();
        step();
        req = 6'h00;
        step();
        check("drop_gnt", gnt, 6'h00);
        check("drop_timeout", NREQ'(timeout), NREQ'(0));
        check("drop_ptr", ptr, 6'h04);

        // Reset in the middle of a grant.
        do_reset();
        req = 6'h10;
        step();
        check("mid_gnt", gnt, 6'h10);
        do_reset();
        check("mid_rst_ptr", ptr, 6'h01);
        req = 6'h3F;
        step();
        check("mid_first", gnt, 6'h01);
        req = '0;
        step();
        step();

        // Random traffic: requests mostly persist, occasional releases.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 63));
            rel = ($urandom_range(0, 9) == 0);
            step();
        end
        rel = 1'b0;
        req = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
